// File: rtl/wb_report_queue.sv
// wb_report_queue
// Snoops the register-file writeback port and queues every write whose
// destination is selected by a programmable mask as a {core, reg, data}
// record. Records drain over a valid/ready handshake. When the queue is
// full and nothing drains, a capture is dropped and counted.
module wb_report_queue #(
  parameter int          CORE        = 0,
  parameter int          DATA_WIDTH  = 32,
  parameter int          DEPTH       = 8,
  parameter logic [31:0] REPORT_MASK = 32'h03FC_0200,
  parameter int          CNT_BITS    = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      write,
  input  logic [4:0]                write_reg,
  input  logic [DATA_WIDTH-1:0]     write_data,
  input  logic                      enable,
  input  logic                      mask_wr,
  input  logic [31:0]               mask_data,
  input  logic                      clear_stats,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [1:0]                out_core,
  output logic [4:0]                out_reg,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic [CNT_BITS-1:0]       drop_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]    DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0]    PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_BITS-1:0] DROP_ONE = CNT_BITS'(1);
  localparam logic [1:0]          CORE_C   = 2'(CORE);

  // Storage and state
  logic [4:0]            reg_mem_r  [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_r [DEPTH];
  logic [31:0]           mask_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic                  out_valid_r;
  logic [4:0]            out_reg_r;
  logic [DATA_WIDTH-1:0] out_data_r;
  logic                  overflow_r;
  logic [CNT_BITS-1:0]   drop_count_r;

  // Next-state terms
  logic                  push_req_s;
  logic                  full_s;
  logic                  pop_s;
  logic                  push_s;
  logic                  drop_s;
  logic [PTR_W-1:0]      rd_ptr_nxt_s;
  logic [PTR_W-1:0]      wr_ptr_nxt_s;
  logic [CNT_W-1:0]      count_nxt_s;
  logic [4:0]            head_reg_nxt_s;
  logic [DATA_WIDTH-1:0] head_data_nxt_s;

  // Decide capture/pop/drop and compute next pointers, count and head record
  always_comb begin
    push_req_s      = write & enable & mask_r[write_reg] & (write_reg != 5'd0);
    full_s          = (count_r == DEPTH_C);
    pop_s           = out_valid_r & out_ready;
    push_s          = push_req_s & (~full_s | pop_s);
    drop_s          = push_req_s & full_s & ~pop_s;
    rd_ptr_nxt_s    = rd_ptr_r;
    wr_ptr_nxt_s    = wr_ptr_r;
    count_nxt_s     = count_r;
    head_reg_nxt_s  = 5'd0;
    head_data_nxt_s = '0;

    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end

    if (push_s) begin
      wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end

    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase

    // The record being written this cycle becomes head only when it lands
    // in the slot the read pointer is about to point at.
    if (count_nxt_s == '0) begin
      head_reg_nxt_s  = 5'd0;
      head_data_nxt_s = '0;
    end else if (push_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
      head_reg_nxt_s  = write_reg;
      head_data_nxt_s = write_data;
    end else begin
      head_reg_nxt_s  = reg_mem_r[rd_ptr_nxt_s];
      head_data_nxt_s = data_mem_r[rd_ptr_nxt_s];
    end
  end

  // Record storage; contents are only meaningful between the pointers
  always_ff @(posedge clock) begin
    if (push_s) begin
      reg_mem_r[wr_ptr_r]  <= write_reg;
      data_mem_r[wr_ptr_r] <= write_data;
    end
  end

  // Queue control, registered head record and capture mask
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mask_r      <= REPORT_MASK;
      rd_ptr_r    <= '0;
      wr_ptr_r    <= '0;
      count_r     <= '0;
      out_valid_r <= 1'b0;
      out_reg_r   <= 5'd0;
      out_data_r  <= '0;
    end else begin
      if (mask_wr) begin
        mask_r <= mask_data;
      end
      rd_ptr_r    <= rd_ptr_nxt_s;
      wr_ptr_r    <= wr_ptr_nxt_s;
      count_r     <= count_nxt_s;
      out_valid_r <= (count_nxt_s != '0);
      out_reg_r   <= head_reg_nxt_s;
      out_data_r  <= head_data_nxt_s;
    end
  end

  // Drop statistics; a clear wins over a drop in the same cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow_r   <= 1'b0;
      drop_count_r <= '0;
    end else if (clear_stats) begin
      overflow_r   <= 1'b0;
      drop_count_r <= '0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
      if (!(&drop_count_r)) begin
        drop_count_r <= drop_count_r + DROP_ONE;
      end
    end
  end

  assign out_valid  = out_valid_r;
  assign out_core   = CORE_C;
  assign out_reg    = out_reg_r;
  assign out_data   = out_data_r;
  assign count      = count_r;
  assign overflow   = overflow_r;
  assign drop_count = drop_count_r;

endmodule

// File: tb/tb_wb_report_queue.sv
// Self-checking bench for wb_report_queue: a queue model records expected
// captures as writes are driven and retires them as the DUT pops records.
module tb_wb_report_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic        write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        enable;
  logic        mask_wr;
  logic [31:0] mask_data;
  logic        clear_stats;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_core;
  logic [4:0]  out_reg;
  logic [31:0] out_data;
  logic [3:0]  count;
  logic        overflow;
  logic [15:0] drop_count;

  int err_cnt = 0;
  int chk_cnt = 0;

  logic [36:0] sb_q[$];
  logic [36:0] out_log[$];
  logic [31:0] m_mask;
  logic        m_ovf;
  int          m_drops;
  bit          m_pop;
  bit          m_cap;

  wb_report_queue dut (
    .clock(clock), .reset(reset), .write(write), .write_reg(write_reg),
    .write_data(write_data), .enable(enable), .mask_wr(mask_wr),
    .mask_data(mask_data), .clear_stats(clear_stats), .out_valid(out_valid),
    .out_ready(out_ready), .out_core(out_core), .out_reg(out_reg),
    .out_data(out_data), .count(count), .overflow(overflow),
    .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] d);
    write      = 1'b1;
    write_reg  = r;
    write_data = d;
    step();
    write      = 1'b0;
  endtask

  // Scoreboard: check DUT against the model, then advance the model with this cycle's inputs
  always @(negedge clock) begin
    if (!reset) begin
      sb_q.delete();
      m_mask  = 32'h03FC_0200;
      m_ovf   = 1'b0;
      m_drops = 0;
      chk("rst_valid", out_valid, 64'd0);
      chk("rst_count", count, 64'd0);
      chk("rst_head", {out_reg, out_data}, 64'd0);
      chk("rst_stats", {overflow, drop_count}, 64'd0);
    end else begin
      chk("valid", out_valid, (sb_q.size() != 0) ? 64'd1 : 64'd0);
      chk("count", count, 64'(sb_q.size()));
      chk("head", {out_reg, out_data}, (sb_q.size() != 0) ? 64'(sb_q[0]) : 64'd0);
      chk("overflow", overflow, 64'(m_ovf));
      chk("drop_count", drop_count, 64'(m_drops));
      chk("core", out_core, 64'd0);
      m_pop = (sb_q.size() != 0) && out_ready;
      m_cap = write && enable && m_mask[write_reg] && (write_reg != 5'd0);
      if (m_pop) begin
        out_log.push_back({out_reg, out_data});
        void'(sb_q.pop_front());
      end
      if (m_cap) begin
        if (sb_q.size() < 8) sb_q.push_back({write_reg, write_data});
        else if (!clear_stats) begin
          m_ovf = 1'b1;
          if (m_drops < 65535) m_drops++;
        end
      end
      if (clear_stats) begin
        m_ovf   = 1'b0;
        m_drops = 0;
      end
      if (mask_wr) m_mask = mask_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; write = 1'b0; write_reg = 5'd0; write_data = 32'd0;
    enable = 1'b1; mask_wr = 1'b0; mask_data = 32'd0; clear_stats = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    step();

    // Basic capture and mask filtering
    out_ready = 1'b1;
    out_log.delete();
    wr(5'd18, 32'h11); wr(5'd9, 32'h22); wr(5'd5, 32'h33);
    repeat (2) step();
    chk("s1_n", out_log.size(), 64'd2);
    chk("s1_r0", out_log[0], {27'd0, 5'd18, 32'h11});
    chk("s1_r1", out_log[1], {27'd0, 5'd9, 32'h22});
    chk("s1_cnt", count, 64'd0);

    // Overflow with stalled consumer, drain order, clear
    out_ready = 1'b0;
    out_log.delete();
    for (int i = 0; i < 10; i++) wr(5'd9, 32'h100 + i);
    chk("s2_cnt", count, 64'd8);
    chk("s2_ovf", overflow, 64'd1);
    chk("s2_drops", drop_count, 64'd2);
    out_ready = 1'b1;
    repeat (9) step();
    chk("s2_n", out_log.size(), 64'd8);
    for (int i = 0; i < 8; i++) chk("s2_order", out_log[i], {27'd0, 5'd9, 32'h100 + i});
    clear_stats = 1'b1; step(); clear_stats = 1'b0;
    chk("s2_clr", {overflow, drop_count}, 64'd0);

    // Full queue with simultaneous push and pop
    out_ready = 1'b0;
    out_log.delete();
    for (int i = 0; i < 8; i++) wr(5'd9, 32'h200 + i);
    chk("s3_full", count, 64'd8);
    out_ready = 1'b1;
    wr(5'd20, 32'hABC);
    out_ready = 1'b0;
    chk("s3_cnt", count, 64'd8);
    chk("s3_ovf", overflow, 64'd0);
    out_ready = 1'b1;
    repeat (9) step();
    chk("s3_n", out_log.size(), 64'd9);
    chk("s3_first", out_log[0], {27'd0, 5'd9, 32'h200});
    chk("s3_last", out_log[8], {27'd0, 5'd20, 32'hABC});

    // Mask write: same-cycle capture uses old mask
    out_log.delete();
    mask_wr = 1'b1; mask_data = 32'h0000_0021;
    wr(5'd18, 32'h44);
    mask_wr = 1'b0;
    wr(5'd18, 32'h55); wr(5'd0, 32'h66); wr(5'd5, 32'h77);
    repeat (2) step();
    chk("s4_n", out_log.size(), 64'd2);
    chk("s4_r0", out_log[0], {27'd0, 5'd18, 32'h44});
    chk("s4_r1", out_log[1], {27'd0, 5'd5, 32'h77});

    // Head held stable while stalled
    out_ready = 1'b0;
    out_log.delete();
    wr(5'd5, 32'h88);
    for (int i = 0; i < 5; i++) begin
      wr(5'd5, 32'h90 + i);
      chk("s5_hold", {out_reg, out_data}, {27'd0, 5'd5, 32'h88});
    end
    out_ready = 1'b1;
    repeat (7) step();
    chk("s5_n", out_log.size(), 64'd6);
    chk("s5_r0", out_log[0], {27'd0, 5'd5, 32'h88});
    chk("s5_r5", out_log[5], {27'd0, 5'd5, 32'h94});

    // Pointer wrap, then reset mid-stream
    out_log.delete();
    for (int i = 0; i < 20; i++) wr(5'd5, 32'h300 + i);
    repeat (2) step();
    chk("s6_n", out_log.size(), 64'd20);
    chk("s6_last", out_log[19], {27'd0, 5'd5, 32'h313});
    out_ready = 1'b0;
    wr(5'd5, 32'h400); wr(5'd5, 32'h401);
    chk("s6_cnt", count, 64'd2);
    reset = 1'b0;
    #1;
    chk("s6_rvalid", out_valid, 64'd0);
    chk("s6_rcnt", count, 64'd0);
    chk("s6_rhead", {out_reg, out_data}, 64'd0);
    step();
    reset = 1'b1;
    out_ready = 1'b1;
    out_log.delete();
    wr(5'd5, 32'hB1); wr(5'd18, 32'hB2);
    repeat (2) step();
    chk("s6_mask_n", out_log.size(), 64'd1);
    chk("s6_mask_r", out_log[0], {27'd0, 5'd18, 32'hB2});
    chk("s6_end_cnt", count, 64'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/wb_report_queue.md
# wb_report_queue

Parametrised successor to the core's saved-register reporting path. Snoops the register-file writeback port, captures every write whose destination register is selected by a runtime-programmable mask, and queues it as a {core, register, data} record. Records drain to the peripheral side over a valid/ready handshake instead of a single-cycle pulse, so back-to-back results are no longer lost. Sits beside `writeback_unit`, driven by the `write`/`write_reg`/`write_data` nets, and replaces the inline `to_peripheral*` registers.

## Interface
- `CORE`, 0: core ID stamped into every record.
- `DATA_WIDTH`, 32: writeback data width.
- `DEPTH`, 8: queue entries; power of two, 2..64.
- `REPORT_MASK`, 32'h03FC_0200: reset value of the capture mask (x9, x18–x25).
- `CNT_BITS`, 16: width of the saturating drop counter.

- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low; all state cleared while low.
- `write`  in  1  register-file write strobe.
- `write_reg`  in  5  destination register.
- `write_data`  in  DATA_WIDTH  data being written.
- `enable`  in  1  capture enable; 0 = no new captures, drain continues.
- `mask_wr`  in  1  load `mask_data` into the capture mask.
- `mask_data`  in  32  new mask, bit n selects register xn.
- `clear_stats`  in  1  clear `overflow` and `drop_count`.
- `out_valid`  out  1  head record available.
- `out_ready`  in  1  consumer accepts head record.
- `out_core`  out  2  `CORE[1:0]`.
- `out_reg`  out  5  head record register.
- `out_data`  out  DATA_WIDTH  head record data.
- `count`  out  $clog2(DEPTH)+1  entries held.
- `overflow`  out  1  sticky: a capture was dropped because the queue was full.
- `drop_count`  out  CNT_BITS  dropped captures, saturating at all-ones.

## Operation
- Capture condition (`push_req`): `write & enable & mask[write_reg] & (write_reg != 0)`. x0 is never captured, even if mask bit 0 is set.
- Mask: 32-bit register. Reset loads `REPORT_MASK`. `mask_wr` loads `mask_data` at the clock edge. A capture in the same cycle as `mask_wr` uses the old mask.
- Queue: circular buffer with read/write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. `count` is kept explicitly. Pop = `out_valid & out_ready`.
- Push is accepted when `count < DEPTH`, or when `count == DEPTH` and a pop happens in the same cycle. Simultaneous push and pop leave `count` unchanged.
- Drop: `push_req` while full with no pop. The record is discarded, `overflow` is set, and `drop_count` increments, saturating.
- `clear_stats` has priority over a same-cycle drop: both `overflow` and `drop_count` go to 0.
- Outputs: `out_reg` and `out_data` show the head entry when `count != 0`, otherwise 0. `out_core` is constant.
- Handshake: once `out_valid` is asserted, the head record is held stable until it is popped. `out_valid` = (`count != 0`).
- `enable` low does not flush the queue. Pops continue normally.

## Timing
- Reset (async assert, sync-safe deassert): `count`=0, pointers=0, `out_valid`=0, `out_reg`=0, `out_data`=0, `overflow`=0, `drop_count`=0, mask=`REPORT_MASK`.
- Capture latency is 1 cycle: a write at edge N with an empty queue gives `out_valid`=1 with the record after edge N.
- Throughput: one push and one pop per cycle. With `out_ready` held at 1, every capture appears for exactly one cycle.
- Reset asserted mid-operation discards all queued records immediately. No partial record survives.
- Wrap-around: after DEPTH pushes and DEPTH pops, pointers return to 0. Order stays FIFO across the wrap.

## Test plan
- Reset, then write x18=0x11, x9=0x22, x5=0x33 on consecutive cycles with `out_ready`=1 -> two records out in order (reg 18, 0x11) then (reg 9, 0x22); x5 produces nothing; `count` returns to 0.
- `out_ready`=0, 10 masked writes with DEPTH=8 -> `count`=8, `overflow`=1, `drop_count`=2. Draining returns the first 8 values in order. Then `clear_stats` -> `overflow`=0, `drop_count`=0.
- Full queue, a masked write and `out_ready`=1 in the same cycle -> no drop, `count` stays 8, new record appears last.
- `mask_wr` with `mask_data`=0x0000_0021 in the same cycle as a write to x18 -> x18 is captured (old mask). The next writes to x18 and x0 are not captured; a write to x5 is captured.
- Hold `out_ready` low with a record at head for 5 cycles while new pushes arrive -> `out_reg`/`out_data` are unchanged until the pop.
- Run 20 push/pop cycles to wrap the pointers twice, then assert `reset` low mid-stream -> outputs are 0 and `count`=0 immediately, mask equals 0x03FC_0200.
